// File: rtl/add8_sched_pkg.sv
// Shared types, defaults and the rotating-priority pick function for the
// add8 round-robin scheduler.
package add8_sched_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned CNTW_DEF = 16;
    localparam int unsigned NREQ_MAX = 8;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First valid entry at or after ptr, wrapping within the first nreq entries.
    function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                      input logic [2:0]          ptr,
                                      input int unsigned         nreq);
        pick_t      res;
        logic [2:0] cand;
        res = '0;
        for (int unsigned off = 0; off < NREQ_MAX; off++) begin
            cand = 3'((32'(ptr) + off) % nreq);
            if (off < nreq && !res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/add8_exact.sv
// Exact combinational 8-bit adder core; the 9-bit output carries the carry-out.
module add8_exact (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [8:0] O
);

    always_comb begin
        O = {1'b0, A} + {1'b0, B};
    end

endmodule

// File: rtl/add8_rr_pick.sv
// Combinational rotating priority encoder: one-hot grant plus index.
module add8_rr_pick
    import add8_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    pick_t pick;

    always_comb begin
        pick   = rr_pick(8'(valid), 3'(ptr), NREQ);
        found  = pick.found;
        idx    = IDW'(pick.idx);
        onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            onehot[i] = pick.found && (idx == IDW'(i));
        end
    end

endmodule

// File: rtl/add8_rr_sched.sv
// Round-robin scheduler sharing one 8-bit adder core between NREQ requesters,
// with a registered valid/ready result slot and saturating grant counters.
module add8_rr_sched
    import add8_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = $clog2(NREQ),
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [8:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    input  logic              cnt_clr,
    input  logic [IDW-1:0]    cnt_sel,
    output logic [CNTW-1:0]   cnt_val
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [8:0]      rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [CNTW-1:0] cnt_q [NREQ];
    logic [CNTW-1:0] cnt_d [NREQ];

    logic [NREQ-1:0] gnt_oh;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_found;
    logic            free;
    logic            accept;
    req_t            reqs [NREQ];
    req_t            sel;
    logic [8:0]      core_o;

    add8_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .onehot (gnt_oh),
        .idx    (gnt_idx),
        .found  (gnt_found)
    );

    add8_exact u_core (
        .A (sel.a),
        .B (sel.b),
        .O (core_o)
    );

    // rst_n gates the grant so nothing is offered while reset is held.
    always_comb begin
        free      = !rsp_valid_q || rsp_ready;
        accept    = free && gnt_found && rst_n;
        req_ready = accept ? gnt_oh : '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            reqs[i].a = req_a[8*i +: 8];
            reqs[i].b = req_b[8*i +: 8];
        end
        sel = reqs[gnt_idx];
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        if (accept) begin
            ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            rsp_valid_d = 1'b1;
            rsp_sum_d   = core_o;
            rsp_id_d    = gnt_idx;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (accept && gnt_idx == IDW'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_val = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (cnt_sel == IDW'(i)) begin
                cnt_val = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_add8_rr_sched.sv
// Self-checking bench for add8_rr_sched with a behavioural scheduler model.
module tb_add8_rr_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned CNTW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [8:0]        rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic              cnt_clr;
    logic [IDW-1:0]    cnt_sel;
    logic [CNTW-1:0]   cnt_val;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int unsigned m_ptr;
    logic        m_valid;
    logic [8:0]  m_sum;
    logic [1:0]  m_id;
    int unsigned m_cnt [NREQ];
    logic [3:0]  exp_ready;
    logic [3:0]  obs_ready;

    add8_rr_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .cnt_clr   (cnt_clr),
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = '0;
        for (int i = 0; i < int'(NREQ); i++) m_cnt[i] = 0;
    endtask

    // Drives one cycle, records predicted and observed req_ready, advances the model.
    task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                        input logic rr, input logic clr);
        int g;
        int idx;
        logic [7:0] av;
        logic [7:0] bv;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        cnt_clr   = clr;
        #1;
        g = -1;
        if (!m_valid || rr) begin
            for (int k = 0; k < 4; k++) begin
                idx = (int'(m_ptr) + k) % 4;
                if (v[idx] && g < 0) g = idx;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        obs_ready = req_ready;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            av      = a[g*8 +: 8];
            bv      = b[g*8 +: 8];
            m_sum   = 9'(av) + 9'(bv);
            m_id    = 2'(g);
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 4;
            if (m_cnt[g] < 15) m_cnt[g]++;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        cnt_clr   = 1'b0;
        cnt_sel   = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 9'd0 || rsp_id !== 2'd0) begin
            failures++; $display("FAIL reset_rsp got=%b/%h/%0d exp=0/000/0", rsp_valid, rsp_sum, rsp_id);
        end
        checks++;
        if (cnt_val !== 4'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_val);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_round_robin();
        int exp_ids [6] = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 32'h80808080, 32'h80808080, 1'b1, 1'b0);
            checks++;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, obs_ready, exp_ready);
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_ids[i]) || rsp_sum !== 9'h100) begin
                failures++;
                $display("FAIL rr_rsp[%0d] got=%b/%0d/%h exp=1/%0d/100", i, rsp_valid, rsp_id, rsp_sum, exp_ids[i]);
            end
        end
        step(4'b0000, '0, '0, 1'b1, 1'b0);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 9'h100 || rsp_id !== 2'd1) begin
            failures++; $display("FAIL rr_drain got=%b/%h/%0d exp=0/100/1", rsp_valid, rsp_sum, rsp_id);
        end
    endtask

    task automatic test_single();
        step(4'b0100, 32'h00100000, 32'h00200000, 1'b1, 1'b0);
        checks++;
        if (obs_ready !== 4'b0100) begin
            failures++; $display("FAIL single_ready got=%b exp=0100", obs_ready);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 9'h030 || rsp_id !== 2'd2) begin
            failures++; $display("FAIL single_rsp got=%b/%h/%0d exp=1/030/2", rsp_valid, rsp_sum, rsp_id);
        end
        step(4'b0000, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        step(4'b0010, 32'h00004000, 32'h00008000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 32'h00004000, 32'h00008000, 1'b0, 1'b0);
            checks++;
            if (obs_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, obs_ready);
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 9'h0C0 || rsp_id !== 2'd1) begin
                failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d exp=1/0c0/1", i, rsp_valid, rsp_sum, rsp_id);
            end
        end
        step(4'b0010, 32'h00001100, 32'h00002200, 1'b1, 1'b0);
        checks++;
        if (obs_ready !== 4'b0010) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=0010", obs_ready);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 9'h033 || rsp_id !== 2'd1) begin
            failures++; $display("FAIL bp_no_bubble got=%b/%h/%0d exp=1/033/1", rsp_valid, rsp_sum, rsp_id);
        end
        step(4'b0000, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_counters();
        step(4'b0000, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(4'b1000, 32'h05000000, 32'h07000000, 1'b1, 1'b0);
        end
        cnt_sel = 2'd3;
        #1;
        checks++;
        if (cnt_val !== 4'd15 || int'(cnt_val) != int'(m_cnt[3])) begin
            failures++; $display("FAIL cnt_saturate got=%0d exp=15", cnt_val);
        end
        step(4'b1000, 32'h05000000, 32'h07000000, 1'b1, 1'b1);
        checks++;
        if (cnt_val !== 4'd0 || rsp_valid !== 1'b1 || rsp_sum !== 9'h00C) begin
            failures++; $display("FAIL cnt_clr_wins got=%0d/%b/%h exp=0/1/00c", cnt_val, rsp_valid, rsp_sum);
        end
        step(4'b1000, 32'h05000000, 32'h07000000, 1'b1, 1'b0);
        checks++;
        if (cnt_val !== 4'd1) begin
            failures++; $display("FAIL cnt_after_clr got=%0d exp=1", cnt_val);
        end
        step(4'b0000, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0]  v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic        clr;
        for (int n = 0; n < 300; n++) begin
            v   = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = $urandom;
            rr  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 40) == 0);
            cnt_sel = 2'($urandom_range(0, 3));
            step(v, a, b, rr, clr);
            checks++;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, obs_ready, exp_ready);
            end
            checks++;
            if (rsp_valid !== m_valid || rsp_sum !== m_sum || rsp_id !== m_id) begin
                failures++;
                $display("FAIL rand_rsp[%0d] got=%b/%h/%0d exp=%b/%h/%0d", n, rsp_valid, rsp_sum, rsp_id, m_valid, m_sum, m_id);
            end
            checks++;
            if (int'(cnt_val) != int'(m_cnt[cnt_sel])) begin
                failures++; $display("FAIL rand_cnt[%0d] sel=%0d got=%0d exp=%0d", n, cnt_sel, cnt_val, m_cnt[cnt_sel]);
            end
        end
        step(4'b0000, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        step(4'b0100, 32'h00330000, 32'h00440000, 1'b1, 1'b0);
        step(4'b0001, 32'h00000001, 32'h00000002, 1'b0, 1'b0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 9'h077) begin
            failures++; $display("FAIL midrst_pre got=%b/%h exp=1/077", rsp_valid, rsp_sum);
        end
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        model_reset();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL midrst_async got=%b/%b exp=0/0000", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL midrst_ptr got=%b exp=0001", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            checks++;
            if (cnt_val !== 4'd0) begin
                failures++; $display("FAIL midrst_cnt[%0d] got=%0d exp=0", i, cnt_val);
            end
        end
        step(4'b1111, 32'h01020304, 32'h10203040, 1'b1, 1'b0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 9'h044) begin
            failures++; $display("FAIL midrst_first got=%b/%0d/%h exp=1/0/044", rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_counters();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add8_rr_sched.md
# add8_rr_sched

Round-robin scheduler that shares one combinational 8-bit adder core (`A[7:0]`, `B[7:0]` -> `O[8:0]`, exact or approximate) between `NREQ` requesters. It arbitrates valid/ready requests, registers the 9-bit result with the winner's ID, and holds it until the consumer accepts it. It also keeps per-requester grant statistics. It sits between the requester pool and the shared arithmetic resource; the core is swapped by changing one instantiation.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: width of the requester ID.
- `CNTW`, 16: width of each grant counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NREQ`  per-requester request valid.
- `req_ready`  out  `NREQ`  per-requester accept; one-hot or zero.
- `req_a`  in  `NREQ*8`  operand A, slice i belongs to requester i.
- `req_b`  in  `NREQ*8`  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  result register holds a result.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_sum`  out  9  core output `O` for the granted operands.
- `rsp_id`  out  `IDW`  index of the requester that produced `rsp_sum`.
- `cnt_clr`  in  1  synchronous clear of all grant counters.
- `cnt_sel`  in  `IDW`  counter read select.
- `cnt_val`  out  `CNTW`  grant count of requester `cnt_sel`; combinational read.

## Operation
- **Slot free:** `free = !rsp_valid | rsp_ready`.
- **Grant:** when `free` and `|req_valid`, grant the first valid requester at or after `ptr`, searching upward with wrap. `req_ready[g]=1`; all other `req_ready` bits are 0. When `!free`, every `req_ready` is 0.
- **Dependency:** `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- **Requester rule:** a requester holds `req_valid`, `req_a` and `req_b` stable until accepted. Dropping `req_valid` early is a protocol violation and is not checked.
- **Accept:** on accept of g:
  - `rsp_sum <= O(req_a[g], req_b[g])`
  - `rsp_id <= g`
  - `rsp_valid <= 1`
  - `ptr <= (g+1) mod NREQ`
- **Drain without refill:** `rsp_valid & rsp_ready` with no new accept sets `rsp_valid <= 0`. `rsp_sum` and `rsp_id` keep their last value.
- **Simultaneous drain and accept:** the register reloads and `rsp_valid` stays 1. There is no bubble.
- **Pointer:** `ptr` moves only on accept.
- **Fairness:** a continuously valid requester is granted within `NREQ` accepts.
- **Grant counters:** the counter for g increments on each accept of g and saturates at `2^CNTW-1`. `cnt_clr` zeroes all counters. If `cnt_clr` coincides with an accept, clear wins and the counter reads 0.
- **Arithmetic:** the core output is used unmodified. No rounding, error correction or carry-in; the 9-bit output carries the core's own MSB.

## Timing
- **Reset values:**
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_id=0`
  - `ptr=0`, so requester 0 has first priority
  - all counters 0
  - `req_ready=0` while `rst_n` is low
- **Latency:** an accept in cycle N gives `rsp_valid=1` with that result in cycle N+1.
- **Throughput:** 1 result per cycle while `rsp_ready=1`.
- **Backpressure:** `rsp_valid` with `!rsp_ready` freezes `rsp_sum`, `rsp_id` and `ptr`. No request is accepted.
- **Reset mid-operation:** asserting `rst_n` low discards a held result immediately (asynchronous). Requests pending at that point must be re-presented. Reset release is synchronised externally.
- **Critical path:** the arbitration mux, then the adder core, then the result register. The core is purely combinational.

## Structure
- **Package `add8_sched_pkg`:**
  - default `NREQ`, `CNTW`
  - the `req_t` struct `{a[7:0], b[7:0]}`
  - the function `rr_pick(valid, ptr)` that returns the grant index and a found flag
- **Sub-module `add8_rr_pick`:**
  - combinational rotating priority encoder, `NREQ` in, one-hot plus index out
  - instantiated once
- **Adder core:** instantiated directly, with ports A/B/O only.

## Test plan
- **Reset:** hold `rst_n=0`, drive `req_valid=4'b1111`.
  - Expect `req_ready=0` and `rsp_valid=0`.
  - After release, requester 0 is granted first.
- **Single request:** requester 2 only, `a=0x10`, `b=0x20`, `rsp_ready=1`.
  - One cycle later, `rsp_valid=1`, `rsp_sum=0x030`, `rsp_id=2`.
- **Round-robin:** all four requesters valid continuously, `rsp_ready=1`.
  - `rsp_id` sequence is 0,1,2,3,0,1.
  - Each requester's operands `a=0x80`, `b=0x80` give `rsp_sum=0x100`.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles with requester 1 valid (`a=0x40`, `b=0x80`).
  - `rsp_sum=0x0C0` stays stable and `req_ready=0` throughout.
  - On release, the next accept occurs in the same cycle as the drain, with no bubble.
- **Counters:** with `CNTW=4`, 20 accepts of requester 3 make `cnt_val`(sel=3) read 15.
  - `cnt_clr` asserted together with an accept reads 0 next cycle.
- **Mid-operation reset:** pulse `rst_n` low while `rsp_valid=1` under backpressure.
  - `rsp_valid` drops asynchronously.
  - `ptr` returns to 0 and the counters read 0.
- **Scoreboard:** every `rsp_sum` is compared against the behavioural model of the instantiated core.
